// File: rtl/gated_counter_if.sv
// Bundle of the gated_counter measurement inputs and latched results.
// The gate-control side (master) drives the four asynchronous controls and
// the measured signal; the counter (slave) returns the latched results.
// dbg_state mirrors the counter FSM state for observation.
interface gated_counter_if #(
  parameter int CNT_W = 32
) ();
  logic             fx_in;
  logic             Counter_EN;
  logic             Latch_EN;
  logic             Counter_Clr;
  logic [CNT_W-1:0] Nx;
  logic [CNT_W-1:0] Ns;
  logic             Data_Valid;
  logic             Overflow;
  logic             Timeout;
  logic [2:0]       dbg_state;

  modport master (
    output fx_in, Counter_EN, Latch_EN, Counter_Clr,
    input  Nx, Ns, Data_Valid, Overflow, Timeout, dbg_state
  );

  modport slave (
    input  fx_in, Counter_EN, Latch_EN, Counter_Clr,
    output Nx, Ns, Data_Valid, Overflow, Timeout, dbg_state
  );
endinterface

// File: rtl/gated_counter.sv
// Reciprocal (equal-precision) gated counter. The preset gate from Counter_EN
// is stretched to an integer number of fx periods: it opens on the first fx
// rising edge and closes on the first fx rising edge after Counter_EN falls.
// Nx counts fx periods and Ns counts clk cycles over that actual gate.
// Optional feature macro GATE_TIMEOUT_EN: bounds the CLOSING wait to TIMEOUT
// clk cycles and reports it through Timeout.
// Data_Valid is a single-cycle pulse with no backpressure: the consumer must
// take Nx/Ns/Overflow/Timeout in the cycle Data_Valid is high (they then hold).
module gated_counter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 50000000
) (
  input logic            clk,
  input logic            rst_n,
  gated_counter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    COUNT   = 3'd2,
    CLOSING = 3'd3,
    DONE    = 3'd4
  } state_t;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("gated_counter: TIMEOUT must be at least 1");
  end

  // two-flop synchronizers plus previous-value flops for edge detection
  logic [1:0] fx_sync_q, fx_sync_d;
  logic [1:0] en_sync_q, en_sync_d;
  logic [1:0] latch_sync_q, latch_sync_d;
  logic [1:0] clr_sync_q, clr_sync_d;
  logic       fx_prev_q, fx_prev_d;
  logic       latch_prev_q, latch_prev_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_x_q, cnt_x_d;
  logic [CNT_W-1:0] cnt_s_q, cnt_s_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] nx_q, nx_d;
  logic [CNT_W-1:0] ns_q, ns_d;
  logic             dv_q, dv_d;
  logic             ovf_out_q, ovf_out_d;
  logic             tmo_out_q, tmo_out_d;

  logic fx_s, en_s, latch_s, clr_s;
  logic fx_rise, latch_rise;
  logic inc_x, inc_s;

`ifdef GATE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  assign fx_s       = fx_sync_q[1];
  assign en_s       = en_sync_q[1];
  assign latch_s    = latch_sync_q[1];
  assign clr_s      = clr_sync_q[1];
  assign fx_rise    = fx_s & ~fx_prev_q;
  assign latch_rise = latch_s & ~latch_prev_q;

  // synchronizer shift and edge-detect history
  always_comb begin
    fx_sync_d    = {fx_sync_q[0], bus.fx_in};
    en_sync_d    = {en_sync_q[0], bus.Counter_EN};
    latch_sync_d = {latch_sync_q[0], bus.Latch_EN};
    clr_sync_d   = {clr_sync_q[0], bus.Counter_Clr};
    fx_prev_d    = fx_s;
    latch_prev_d = latch_s;
  end

  // gate FSM, saturating counters and result latch; Clr overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_x_d   = cnt_x_q;
    cnt_s_d   = cnt_s_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    nx_d      = nx_q;
    ns_d      = ns_q;
    dv_d      = 1'b0;
    ovf_out_d = ovf_out_q;
    tmo_out_d = tmo_out_q;
    inc_x     = 1'b0;
    inc_s     = 1'b0;
`ifdef GATE_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    if (clr_s) begin
      state_d = IDLE;
      cnt_x_d = '0;
      cnt_s_d = '0;
      ovf_d   = 1'b0;
      tmo_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en_s) state_d = ARMED;
        end
        ARMED: begin
          // the opening fx edge is not counted
          if (fx_rise)    state_d = COUNT;
          else if (!en_s) state_d = DONE;
        end
        COUNT: begin
          inc_s = 1'b1;
          inc_x = fx_rise;
          if (!en_s) begin
            state_d = CLOSING;
`ifdef GATE_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
        CLOSING: begin
          inc_s = 1'b1;
          if (fx_rise) begin
            // closing edge is counted so the gate spans whole fx periods
            inc_x   = 1'b1;
            state_d = DONE;
          end
`ifdef GATE_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
            state_d = DONE;
            tmo_d   = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          if (latch_rise) begin
            nx_d      = cnt_x_q;
            ns_d      = cnt_s_q;
            ovf_out_d = ovf_q;
            tmo_out_d = tmo_q;
            dv_d      = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (inc_x) begin
      if (cnt_x_q == '1) ovf_d   = 1'b1;
      else               cnt_x_d = cnt_x_q + 1'b1;
    end
    if (inc_s) begin
      if (cnt_s_q == '1) ovf_d   = 1'b1;
      else               cnt_s_d = cnt_s_q + 1'b1;
    end
  end

  // state register; reset discards any measurement in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fx_sync_q    <= '0;
      en_sync_q    <= '0;
      latch_sync_q <= '0;
      clr_sync_q   <= '0;
      fx_prev_q    <= 1'b0;
      latch_prev_q <= 1'b0;
      state_q      <= IDLE;
      cnt_x_q      <= '0;
      cnt_s_q      <= '0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      nx_q         <= '0;
      ns_q         <= '0;
      dv_q         <= 1'b0;
      ovf_out_q    <= 1'b0;
      tmo_out_q    <= 1'b0;
`ifdef GATE_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      fx_sync_q    <= fx_sync_d;
      en_sync_q    <= en_sync_d;
      latch_sync_q <= latch_sync_d;
      clr_sync_q   <= clr_sync_d;
      fx_prev_q    <= fx_prev_d;
      latch_prev_q <= latch_prev_d;
      state_q      <= state_d;
      cnt_x_q      <= cnt_x_d;
      cnt_s_q      <= cnt_s_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      nx_q         <= nx_d;
      ns_q         <= ns_d;
      dv_q         <= dv_d;
      ovf_out_q    <= ovf_out_d;
      tmo_out_q    <= tmo_out_d;
`ifdef GATE_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign bus.Nx         = nx_q;
  assign bus.Ns         = ns_q;
  assign bus.Data_Valid = dv_q;
  assign bus.Overflow   = ovf_out_q;
  assign bus.Timeout    = tmo_out_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_gated_counter.sv
// Directed bench for gated_counter: a 32-bit instance and an 8-bit instance
// share the same stimulus; results are checked against hand-computed values.
module tb_gated_counter;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COUNT   = 3'd2;
  localparam logic [2:0] S_CLOSING = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic clk;
  logic rst_n;
  logic fx_in;
  logic counter_en;
  logic latch_en;
  logic counter_clr;

  int n_cmp;
  int n_mis;
  int dv_cnt;
  int dv_wide;
  int dv_base;
  logic dv_prev;

  gated_counter_if #(.CNT_W(32)) bus32 ();
  gated_counter_if #(.CNT_W(8))  bus8 ();

  assign bus32.fx_in       = fx_in;
  assign bus32.Counter_EN  = counter_en;
  assign bus32.Latch_EN    = latch_en;
  assign bus32.Counter_Clr = counter_clr;
  assign bus8.fx_in        = fx_in;
  assign bus8.Counter_EN   = counter_en;
  assign bus8.Latch_EN     = latch_en;
  assign bus8.Counter_Clr  = counter_clr;

  gated_counter #(.CNT_W(32), .TIMEOUT(100)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  gated_counter #(.CNT_W(8), .TIMEOUT(100)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data_Valid pulse monitor on the 32-bit instance
  initial begin
    dv_cnt  = 0;
    dv_wide = 0;
    dv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus32.Data_Valid === 1'b1) begin
        dv_cnt++;
        if (dv_prev === 1'b1) dv_wide++;
      end
      dv_prev = bus32.Data_Valid;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // fx square wave of the given period starting at offset (stops at fx_stop);
  // Counter_EN high for the first gate_len cycles
  task automatic run_gate(input int period, input int offset, input int gate_len,
                          input int fx_stop, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if (period > 0 && c >= offset && c < fx_stop)
        fx_in = (((c - offset) % period) < (period / 2));
      else
        fx_in = 1'b0;
      counter_en = (c < gate_len);
      @(negedge clk);
    end
    fx_in = 1'b0;
  endtask

  task automatic pulse_latch();
    latch_en = 1'b1;
    step(4);
    latch_en = 1'b0;
    step(6);
  endtask

  task automatic pulse_clr();
    counter_clr = 1'b1;
    step(4);
    counter_clr = 1'b0;
    step(4);
  endtask

  // directed sequence
  initial begin
    n_cmp       = 0;
    n_mis       = 0;
    rst_n       = 1'b0;
    fx_in       = 1'b0;
    counter_en  = 1'b0;
    latch_en    = 1'b0;
    counter_clr = 1'b0;
    step(3);

    check("reset_nx", bus32.Nx, 32'd0);
    check("reset_ns", bus32.Ns, 32'd0);
    check("reset_dv", {31'd0, bus32.Data_Valid}, 32'd0);
    check("reset_ovf", {31'd0, bus32.Overflow}, 32'd0);
    check("reset_tmo", {31'd0, bus32.Timeout}, 32'd0);
    check("reset_state", {29'd0, bus32.dbg_state}, {29'd0, S_IDLE});
    rst_n = 1'b1;
    step(3);

    // fx period 50, gate 1000
    run_gate(50, 10, 1000, 1100, 1100);
    check("p50_done", {29'd0, bus32.dbg_state}, {29'd0, S_DONE});
    check("p50_no_dv_before_latch", dv_cnt, 0);
    dv_base = dv_cnt;
    pulse_latch();
    check("p50_nx", bus32.Nx, 32'd20);
    check("p50_ns", bus32.Ns, 32'd1000);
    check("p50_dv_count", dv_cnt, dv_base + 1);
    check("p50_dv_width", dv_wide, 0);
    check("p50_ovf", {31'd0, bus32.Overflow}, 32'd0);
    check("p50_tmo", {31'd0, bus32.Timeout}, 32'd0);
    pulse_clr();
    check("p50_clr_idle", {29'd0, bus32.dbg_state}, {29'd0, S_IDLE});

    // Clr mid-COUNT discards the gate, later Latch ignored
    run_gate(50, 10, 1000, 1000, 500);
    check("clr_mid_in_count", {29'd0, bus32.dbg_state}, {29'd0, S_COUNT});
    counter_clr = 1'b1;
    step(2);
    counter_en = 1'b0;
    step(3);
    counter_clr = 1'b0;
    step(4);
    check("clr_mid_idle", {29'd0, bus32.dbg_state}, {29'd0, S_IDLE});
    dv_base = dv_cnt;
    pulse_latch();
    check("clr_mid_no_dv", dv_cnt, dv_base);
    check("clr_mid_nx_hold", bus32.Nx, 32'd20);
    check("clr_mid_ns_hold", bus32.Ns, 32'd1000);

    // fx period 37, gate 500: gate stretched to 14 periods
    run_gate(37, 10, 500, 600, 600);
    check("p37_done", {29'd0, bus32.dbg_state}, {29'd0, S_DONE});
    dv_base = dv_cnt;
    pulse_latch();
    check("p37_nx", bus32.Nx, 32'd14);
    check("p37_ns", bus32.Ns, 32'd518);
    check("p37_dv_count", dv_cnt, dv_base + 1);
    pulse_clr();

    // fx held low: gate closes with zero counts; Counter_EN in DONE ignored
    run_gate(0, 0, 300, 0, 320);
    check("nofx_done", {29'd0, bus32.dbg_state}, {29'd0, S_DONE});
    counter_en = 1'b1;
    step(20);
    check("nofx_en_in_done", {29'd0, bus32.dbg_state}, {29'd0, S_DONE});
    counter_en = 1'b0;
    step(4);
    dv_base = dv_cnt;
    pulse_latch();
    check("nofx_nx", bus32.Nx, 32'd0);
    check("nofx_ns", bus32.Ns, 32'd0);
    check("nofx_dv_count", dv_cnt, dv_base + 1);
    check("nofx_dv_width", dv_wide, 0);
    pulse_clr();

    // fx period 4, gate 400: 8-bit Ns saturates
    run_gate(4, 2, 400, 450, 450);
    pulse_latch();
    check("sat8_nx", {24'd0, bus8.Nx}, 32'd100);
    check("sat8_ns", {24'd0, bus8.Ns}, 32'd255);
    check("sat8_ovf", {31'd0, bus8.Overflow}, 32'd1);
    check("sat32_nx", bus32.Nx, 32'd100);
    check("sat32_ns", bus32.Ns, 32'd400);
    check("sat32_ovf", {31'd0, bus32.Overflow}, 32'd0);
    pulse_clr();

    // fx stops after Counter_EN falls
    run_gate(20, 5, 200, 200, 350);
    dv_base = dv_cnt;
`ifdef GATE_TIMEOUT_EN
    check("tmo_done", {29'd0, bus32.dbg_state}, {29'd0, S_DONE});
    pulse_latch();
    check("tmo_flag", {31'd0, bus32.Timeout}, 32'd1);
    check("tmo_nx", bus32.Nx, 32'd9);
    check("tmo_ns", bus32.Ns, 32'd295);
    check("tmo_dv_count", dv_cnt, dv_base + 1);
`else
    check("wait_closing", {29'd0, bus32.dbg_state}, {29'd0, S_CLOSING});
    pulse_latch();
    check("wait_no_dv", dv_cnt, dv_base);
    check("wait_tmo_zero", {31'd0, bus32.Timeout}, 32'd0);
    check("wait_nx_hold", bus32.Nx, 32'd100);
`endif
    pulse_clr();

    // reset mid-COUNT clears outputs at once and yields no Data_Valid
    run_gate(50, 10, 1000, 1000, 300);
    check("rst_mid_in_count", {29'd0, bus32.dbg_state}, {29'd0, S_COUNT});
    dv_base = dv_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_nx", bus32.Nx, 32'd0);
    check("rst_mid_ns", bus32.Ns, 32'd0);
    check("rst_mid_dv", {31'd0, bus32.Data_Valid}, 32'd0);
    check("rst_mid_ovf8", {31'd0, bus8.Overflow}, 32'd0);
    check("rst_mid_tmo", {31'd0, bus32.Timeout}, 32'd0);
    check("rst_mid_state", {29'd0, bus32.dbg_state}, {29'd0, S_IDLE});
    counter_en = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(20);
    check("rst_mid_no_dv", dv_cnt, dv_base);
    check("rst_mid_idle_after", {29'd0, bus32.dbg_state}, {29'd0, S_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
